// File: rtl/capture_cmd_ctrl.sv
// capture_cmd_ctrl: command sequencer between the UART command receiver and the
// capture engine. Holds the capture configuration, owns capture_done, answers
// commands with ACK/NAK/status bytes and paces channel RAM dumps onto the UART.
module capture_cmd_ctrl #(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] NAK_BYTE = 8'hEE,
    parameter int         ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cmd,
    input  logic              cmd_rdy,
    output logic              clr_cmd_rdy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [1:0]        trig_type,
    output logic [ADDR_W-1:0] trig_pos,
    output logic [3:0]        dec_pwr,
    output logic              capture_done,
    input  logic              set_capture_done,
    input  logic              armed,
    output logic              start_dump,
    output logic [1:0]        ch_sel,
    input  logic              send_dump,
    input  logic [7:0]        dump_data,
    output logic              dump_sent,
    input  logic              dump_finished,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_RESP      = 3'd2,
        S_RESP_WAIT = 3'd3,
        S_DUMP_REQ  = 3'd4,
        S_DUMP_WAIT = 3'd5,
        S_DUMP_TX   = 3'd6
    } state_t;

    localparam logic [3:0] OP_DUMP     = 4'd1;
    localparam logic [3:0] OP_CFG_TRIG = 4'd2;
    localparam logic [3:0] OP_SET_DEC  = 4'd3;
    localparam logic [3:0] OP_SET_POS  = 4'd4;
    localparam logic [3:0] OP_STATUS   = 4'd5;

    state_t              state_q, state_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [1:0]          trig_type_q, trig_type_d;
    logic [ADDR_W-1:0]   trig_pos_q, trig_pos_d;
    logic [3:0]          dec_pwr_q, dec_pwr_d;
    logic                capture_done_q, capture_done_d;
    logic [1:0]          ch_sel_q, ch_sel_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                clr_cmd_rdy_q, clr_cmd_rdy_d;
    logic                start_dump_q, start_dump_d;
    logic                dump_sent_q, dump_sent_d;
    logic                rearm_hold_q, rearm_hold_d;
    logic                busy_q, busy_d;
    logic                cfg_clear_s;
    logic                unused_s;

    // Reserved command bits carry no meaning for this block.
    assign unused_s = ^cmd_q[11:10];

    // Next-state, register-write and response selection logic.
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        trig_type_d    = trig_type_q;
        trig_pos_d     = trig_pos_q;
        dec_pwr_d      = dec_pwr_q;
        ch_sel_d       = ch_sel_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        clr_cmd_rdy_d  = 1'b0;
        start_dump_d   = 1'b0;
        dump_sent_d    = 1'b0;
        // send_dump is still high for the cycle after dump_sent; block it too.
        rearm_hold_d   = dump_sent_q;
        cfg_clear_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_rdy) begin
                    cmd_d         = cmd;
                    clr_cmd_rdy_d = 1'b1;
                    state_d       = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                // Default answer is NAK; legal opcodes override it below.
                tx_data_d  = NAK_BYTE;
                tx_start_d = 1'b1;
                state_d    = S_RESP;
                case (cmd_q[15:12])
                    OP_DUMP: begin
                        if ((cmd_q[9:8] != 2'd0) && capture_done_q) begin
                            tx_data_d    = tx_data_q;
                            tx_start_d   = 1'b0;
                            ch_sel_d     = cmd_q[9:8];
                            start_dump_d = 1'b1;
                            state_d      = S_DUMP_REQ;
                        end else begin
                            tx_data_d = NAK_BYTE;
                        end
                    end
                    OP_CFG_TRIG: begin
                        trig_type_d = cmd_q[1:0];
                        cfg_clear_s = 1'b1;
                        tx_data_d   = ACK_BYTE;
                    end
                    OP_SET_DEC: begin
                        dec_pwr_d = cmd_q[3:0];
                        tx_data_d = ACK_BYTE;
                    end
                    OP_SET_POS: begin
                        trig_pos_d = cmd_q[ADDR_W-1:0];
                        tx_data_d  = ACK_BYTE;
                    end
                    OP_STATUS: begin
                        tx_data_d = {capture_done_q, armed, trig_type_q, dec_pwr_q};
                    end
                    default: begin
                        tx_data_d = NAK_BYTE;
                    end
                endcase
            end
            S_RESP: begin
                state_d = S_RESP_WAIT;
            end
            S_RESP_WAIT: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP_WAIT;
                end
            end
            S_DUMP_REQ: begin
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (dump_finished) begin
                    state_d = S_IDLE;
                end else if (send_dump && !dump_sent_q && !rearm_hold_q) begin
                    tx_data_d  = dump_data;
                    tx_start_d = 1'b1;
                    state_d    = S_DUMP_TX;
                end else begin
                    state_d = S_DUMP_WAIT;
                end
            end
            S_DUMP_TX: begin
                if (tx_done) begin
                    dump_sent_d = 1'b1;
                    state_d     = S_DUMP_WAIT;
                end else begin
                    state_d = S_DUMP_TX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A capture completing in the same cycle as a re-arm wins.
        if (set_capture_done) begin
            capture_done_d = 1'b1;
        end else if (cfg_clear_s) begin
            capture_done_d = 1'b0;
        end else begin
            capture_done_d = capture_done_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset returns everything to idle defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_q          <= 16'h0000;
            trig_type_q    <= 2'b00;
            trig_pos_q     <= '0;
            dec_pwr_q      <= 4'h0;
            capture_done_q <= 1'b0;
            ch_sel_q       <= 2'b00;
            tx_data_q      <= 8'h00;
            tx_start_q     <= 1'b0;
            clr_cmd_rdy_q  <= 1'b0;
            start_dump_q   <= 1'b0;
            dump_sent_q    <= 1'b0;
            rearm_hold_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            trig_type_q    <= trig_type_d;
            trig_pos_q     <= trig_pos_d;
            dec_pwr_q      <= dec_pwr_d;
            capture_done_q <= capture_done_d;
            ch_sel_q       <= ch_sel_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            clr_cmd_rdy_q  <= clr_cmd_rdy_d;
            start_dump_q   <= start_dump_d;
            dump_sent_q    <= dump_sent_d;
            rearm_hold_q   <= rearm_hold_d;
            busy_q         <= busy_d;
        end
    end

    assign clr_cmd_rdy  = clr_cmd_rdy_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign trig_type    = trig_type_q;
    assign trig_pos     = trig_pos_q;
    assign dec_pwr      = dec_pwr_q;
    assign capture_done = capture_done_q;
    assign start_dump   = start_dump_q;
    assign ch_sel       = ch_sel_q;
    assign dump_sent    = dump_sent_q;
    assign busy         = busy_q;

endmodule
